// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
//
// Contents:
//   arb_state_e             - transaction FSM states (idle, address phase, data phase)
//   owner_e                 - which requester owns the in-flight transaction
//   SizeByte/SizeHalf/Word  - encodings of the 2-bit access-size field
//   StreakW                 - width of the MEM-grant streak counter (limit is at most 15)
//   streak_after_mem_grant  - streak update applied when MEM wins arbitration
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StData = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnIf   = 2'd1,
      OwnMem  = 2'd2
   } owner_e;

   localparam logic [1:0] SizeByte = 2'd0;
   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;

   localparam int unsigned StreakW = 4;

   // A MEM win only counts against IF when IF was actually waiting; otherwise
   // the streak restarts. The count saturates at the limit.
   function automatic logic [StreakW-1:0] streak_after_mem_grant(
      input logic [StreakW-1:0] streak,
      input logic               inst_waiting,
      input logic [StreakW-1:0] max_streak
   );
      if (!inst_waiting) begin
         return '0;
      end
      if (streak >= max_streak) begin
         return max_streak;
      end
      return streak + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory-port arbiter.
//
// Groups the two requester handshakes (instruction fetch, data access), the
// shared SRAM-like port and the stall requests towards the stall controller.
//   master - the arbiter's view: consumes requests and port responses, drives
//            completions, the port request and the stall requests.
//   slave  - the environment's view (pipeline stages and memory together).
interface mem_port_arbiter_if #(
   parameter int unsigned AddrW = 32,
   parameter int unsigned DataW = 32
);

   // Instruction-fetch requester
   logic             inst_req;
   logic [AddrW-1:0] inst_addr;
   logic [DataW-1:0] inst_rdata;
   logic             inst_done;

   // Data-access requester
   logic             data_req;
   logic             data_wr;
   logic [1:0]       data_size;
   logic [AddrW-1:0] data_addr;
   logic [DataW-1:0] data_wdata;
   logic [DataW-1:0] data_rdata;
   logic             data_done;

   // Shared memory port
   logic             mem_req;
   logic             mem_wr;
   logic [1:0]       mem_size;
   logic [AddrW-1:0] mem_addr;
   logic [DataW-1:0] mem_wdata;
   logic             mem_addr_ok;
   logic             mem_data_ok;
   logic [DataW-1:0] mem_rdata;

   // Stall requests
   logic             stall_req_if;
   logic             stall_req_mem;

   modport master (
      input  inst_req, inst_addr,
      output inst_rdata, inst_done,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_done,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output stall_req_if, stall_req_mem
   );

   modport slave (
      output inst_req, inst_addr,
      input  inst_rdata, inst_done,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_done,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  stall_req_if, stall_req_mem
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares one SRAM-like port between instruction fetch (IF)
// and data access (MEM), one transaction at a time.
//
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_ni  - asynchronous active-low reset
//   bus_io  - mem_port_arbiter_if.master: requester handshakes, memory port,
//             stall requests
//
// Arbitration happens only in idle. MEM wins ties unless it has already won
// MaxDataStreak consecutive arbitrations while IF was waiting, in which case IF
// wins. A granted request is latched into the port registers, which hold steady
// until the port accepts the address. Completion, read data and stall requests
// are combinational so a zero-wait port finishes in the first request cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AddrW         = 32,
   parameter int unsigned DataW         = 32,
   parameter int unsigned MaxDataStreak = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   mem_port_arbiter_if.master bus_io
);

   localparam logic [StreakW-1:0] MaxStreak = StreakW'(MaxDataStreak);

   arb_state_e         state_q;
   owner_e             owner_q;
   logic [StreakW-1:0] streak_q;

   logic               mem_req_q;
   logic               mem_wr_q;
   logic [1:0]         mem_size_q;
   logic [AddrW-1:0]   mem_addr_q;
   logic [DataW-1:0]   mem_wdata_q;

   logic               if_wins;
   logic               grant_if;
   logic               grant_mem;
   logic               xfer_done;
   logic               inst_done;
   logic               data_done;

   // ------------------------------------------------------------------------
   // Arbitration (meaningful only in idle)
   // ------------------------------------------------------------------------
   always_comb begin
      if_wins   = bus_io.inst_req && (!bus_io.data_req || (streak_q >= MaxStreak));
      grant_if  = (state_q == StIdle) && if_wins;
      grant_mem = (state_q == StIdle) && bus_io.data_req && !if_wins;
   end

   // Data-ok only counts once the address is (or is being) accepted; a stray
   // data-ok in idle or in an unaccepted address phase is ignored.
   always_comb begin
      xfer_done = bus_io.mem_data_ok &&
                  (((state_q == StAddr) && bus_io.mem_addr_ok) || (state_q == StData));
   end

   // ------------------------------------------------------------------------
   // Transaction FSM with registered port outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         owner_q     <= OwnNone;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_size_q  <= 2'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_mem) begin
                  state_q     <= StAddr;
                  owner_q     <= OwnMem;
                  streak_q    <= streak_after_mem_grant(streak_q, bus_io.inst_req, MaxStreak);
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= bus_io.data_wr;
                  mem_size_q  <= bus_io.data_size;
                  mem_addr_q  <= bus_io.data_addr;
                  mem_wdata_q <= bus_io.data_wdata;
               end else if (grant_if) begin
                  state_q     <= StAddr;
                  owner_q     <= OwnIf;
                  streak_q    <= '0;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b0;
                  mem_size_q  <= SizeWord;
                  mem_addr_q  <= bus_io.inst_addr;
                  mem_wdata_q <= '0;
               end
            end

            StAddr: begin
               if (bus_io.mem_addr_ok) begin
                  mem_req_q <= 1'b0;
                  if (bus_io.mem_data_ok) begin
                     state_q <= StIdle;
                     owner_q <= OwnNone;
                  end else begin
                     state_q <= StData;
                  end
               end
            end

            StData: begin
               if (bus_io.mem_data_ok) begin
                  state_q <= StIdle;
                  owner_q <= OwnNone;
               end
            end

            default: begin
               state_q   <= StIdle;
               owner_q   <= OwnNone;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Port outputs
   // ------------------------------------------------------------------------
   assign bus_io.mem_req   = mem_req_q;
   assign bus_io.mem_wr    = mem_wr_q;
   assign bus_io.mem_size  = mem_size_q;
   assign bus_io.mem_addr  = mem_addr_q;
   assign bus_io.mem_wdata = mem_wdata_q;

   // ------------------------------------------------------------------------
   // Completion, read data and stall requests
   // ------------------------------------------------------------------------
   // Gated by reset so a requester holding its level request while reset is
   // asserted does not see a stall or completion.
   assign inst_done = rst_ni && (owner_q == OwnIf)  && xfer_done;
   assign data_done = rst_ni && (owner_q == OwnMem) && xfer_done;

   assign bus_io.inst_done  = inst_done;
   assign bus_io.data_done  = data_done;
   assign bus_io.inst_rdata = inst_done ? bus_io.mem_rdata : '0;
   assign bus_io.data_rdata = data_done ? bus_io.mem_rdata : '0;

   assign bus_io.stall_req_if  = rst_ni && bus_io.inst_req && !inst_done;
   assign bus_io.stall_req_mem = rst_ni && bus_io.data_req && !data_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int MaxStreak = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AddrW(32), .DataW(32)) bus ();

   mem_port_arbiter #(
      .AddrW        (32),
      .DataW        (32),
      .MaxDataStreak(MaxStreak)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus_io(bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=no_completion required=completion at %0t", name, $time);
   endtask

   // ---------------------------------------------------------------------
   // Memory responder: address accepted after ao_wait request cycles, data
   // returned do_wait cycles after acceptance (0 = same cycle).
   // ---------------------------------------------------------------------
   int          ao_wait    = 0;
   int          do_wait    = 0;
   int          rq_cnt     = 0;
   int          d_cnt      = 0;
   logic        d_phase    = 1'b0;
   logic        spur_ok    = 1'b0;
   logic [31:0] resp_rdata = '0;

   assign bus.mem_addr_ok = rst_n && bus.mem_req && (rq_cnt >= ao_wait);
   assign bus.mem_data_ok = spur_ok || (bus.mem_addr_ok && (do_wait == 0)) ||
                            (d_phase && (d_cnt >= do_wait));
   assign bus.mem_rdata   = resp_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_cnt  <= 0;
         d_phase <= 1'b0;
         d_cnt   <= 0;
      end else begin
         rq_cnt <= (bus.mem_req && !bus.mem_addr_ok) ? rq_cnt + 1 : 0;
         if (bus.mem_addr_ok && !bus.mem_data_ok) begin
            d_phase <= 1'b1;
            d_cnt   <= 1;
         end else if (d_phase && bus.mem_data_ok) begin
            d_phase <= 1'b0;
            d_cnt   <= 0;
         end else if (d_phase) begin
            d_cnt <= d_cnt + 1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Requester drivers: pop a queued request, hold it until DONE is seen.
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   dreq_t       dq[$];
   logic [31:0] iq[$];
   logic        kill  = 1'b0;
   logic        d_req = 1'b0;
   logic        i_req = 1'b0;

   assign bus.data_req = d_req && !kill;
   assign bus.inst_req = i_req && !kill;

   initial begin : data_drv
      int    wait_cyc;
      logic  seen;
      dreq_t r;
      wait_cyc       = 0;
      bus.data_wr    = 1'b0;
      bus.data_size  = 2'd0;
      bus.data_addr  = '0;
      bus.data_wdata = '0;
      forever begin
         @(negedge clk);
         seen = bus.data_done;
         @(posedge clk);
         #1;
         if (kill) begin
            d_req = 1'b0;
            dq.delete();
            wait_cyc = 0;
         end else begin
            if (d_req && seen) begin
               d_req = 1'b0;
            end else if (d_req) begin
               wait_cyc++;
               if (wait_cyc > 100) begin
                  note_fail("data_timeout");
                  d_req = 1'b0;
               end
            end
            if (!d_req && dq.size() > 0) begin
               r              = dq.pop_front();
               bus.data_wr    = r.wr;
               bus.data_size  = r.size;
               bus.data_addr  = r.addr;
               bus.data_wdata = r.wdata;
               d_req          = 1'b1;
               wait_cyc       = 0;
            end
         end
      end
   end

   initial begin : inst_drv
      int   wait_cyc;
      logic seen;
      wait_cyc      = 0;
      bus.inst_addr = '0;
      forever begin
         @(negedge clk);
         seen = bus.inst_done;
         @(posedge clk);
         #1;
         if (kill) begin
            i_req = 1'b0;
            iq.delete();
            wait_cyc = 0;
         end else begin
            if (i_req && seen) begin
               i_req = 1'b0;
            end else if (i_req) begin
               wait_cyc++;
               if (wait_cyc > 100) begin
                  note_fail("inst_timeout");
                  i_req = 1'b0;
               end
            end
            if (!i_req && iq.size() > 0) begin
               bus.inst_addr = iq.pop_front();
               i_req         = 1'b1;
               wait_cyc      = 0;
            end
         end
      end
   end

   task automatic push_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
      dreq_t r;
      r.wr    = wr;
      r.size  = size;
      r.addr  = addr;
      r.wdata = wdata;
      dq.push_back(r);
   endtask

   // ---------------------------------------------------------------------
   // Transaction-level model: one outstanding transfer, tie-break by the
   // count of consecutive MEM wins over a waiting IF.
   // ---------------------------------------------------------------------
   bit          m_active   = 1'b0;
   bit          m_accepted = 1'b0;
   int          m_owner    = 0;  // 1 = IF, 2 = MEM
   int          m_streak   = 0;
   logic [31:0] m_addr     = '0;
   logic [31:0] m_wdata    = '0;
   logic        m_wr       = 1'b0;
   logic [1:0]  m_size     = 2'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active   = 1'b0;
         m_accepted = 1'b0;
         m_owner    = 0;
         m_streak   = 0;
      end else if (!m_active) begin
         if (bus.data_req && (!bus.inst_req || m_streak < MaxStreak)) begin
            m_active   = 1'b1;
            m_accepted = 1'b0;
            m_owner    = 2;
            m_addr     = bus.data_addr;
            m_wdata    = bus.data_wdata;
            m_wr       = bus.data_wr;
            m_size     = bus.data_size;
            m_streak   = bus.inst_req ? ((m_streak + 1 > MaxStreak) ? MaxStreak : m_streak + 1)
                                      : 0;
         end else if (bus.inst_req) begin
            m_active   = 1'b1;
            m_accepted = 1'b0;
            m_owner    = 1;
            m_addr     = bus.inst_addr;
            m_wr       = 1'b0;
            m_size     = 2'd2;
            m_streak   = 0;
         end
      end else begin
         if (bus.mem_data_ok && (m_accepted || bus.mem_addr_ok)) begin
            m_active = 1'b0;
         end else if (!m_accepted && bus.mem_addr_ok) begin
            m_accepted = 1'b1;
         end
      end
   end

   // Compare process
   logic c_cpl, c_id, c_dd, c_req;
   always @(negedge clk) begin
      if (rst_n) begin
         c_cpl = m_active && bus.mem_data_ok && (m_accepted || bus.mem_addr_ok);
         c_id  = c_cpl && (m_owner == 1);
         c_dd  = c_cpl && (m_owner == 2);
         c_req = m_active && !m_accepted;
         check("mem_req", 32'(bus.mem_req), 32'(c_req));
         if (c_req) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_wr", 32'(bus.mem_wr), 32'(m_wr));
            check("mem_size", 32'(bus.mem_size), 32'(m_size));
            if (m_owner == 2) check("mem_wdata", bus.mem_wdata, m_wdata);
         end
         check("inst_done", 32'(bus.inst_done), 32'(c_id));
         check("data_done", 32'(bus.data_done), 32'(c_dd));
         check("inst_rdata", bus.inst_rdata, c_id ? bus.mem_rdata : 32'h0);
         check("data_rdata", bus.data_rdata, c_dd ? bus.mem_rdata : 32'h0);
         check("stall_if", 32'(bus.stall_req_if), 32'(bus.inst_req && !c_id));
         check("stall_mem", 32'(bus.stall_req_mem), 32'(bus.data_req && !c_dd));
      end
   end

   // A requester must hold its request until its transaction completes.
   always @(negedge clk) begin
      if (rst_n && m_active) begin
         if (m_owner == 1) assert (bus.inst_req) else $error("IF request withdrawn early");
         if (m_owner == 2) assert (bus.data_req) else $error("MEM request withdrawn early");
      end
   end

   // Event counters for the hand-computed expectations
   int          n_ddone = 0, n_idone = 0, n_memreq = 0, n_stall_if = 0, n_stall_mem = 0;
   int          n_store_ok = 0;
   logic [31:0] last_drdata = '0, last_irdata = '0;
   logic        prev_req = 1'b0;
   logic [31:0] glog[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (bus.data_done) begin
            n_ddone++;
            last_drdata = bus.data_rdata;
         end
         if (bus.inst_done) begin
            n_idone++;
            last_irdata = bus.inst_rdata;
         end
         if (bus.mem_req) n_memreq++;
         if (bus.stall_req_if) n_stall_if++;
         if (bus.stall_req_mem) n_stall_mem++;
         if (bus.mem_req && bus.mem_wr && bus.mem_size == 2'd0 && bus.mem_addr == 32'h300 &&
             bus.mem_wdata == 32'hAB) n_store_ok++;
         if (bus.mem_req && !prev_req) glog.push_back(bus.mem_addr);
         prev_req = bus.mem_req;
      end
   end

   function automatic logic [31:0] glog_at(input int i);
      if (i < 0 || i >= glog.size()) return 32'hFFFF_FFFF;
      return glog[i];
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((dq.size() != 0 || iq.size() != 0 || bus.data_req || bus.inst_req || m_active) &&
             n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) note_fail(name);
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Directed tests
   // ---------------------------------------------------------------------
   initial begin : main
      int          s_dd, s_id, s_sm, s_si, s_mr, s_st, g0;
      logic [31:0] exp_order[11];

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_mem_req", 32'(bus.mem_req), 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_data_done", 32'(bus.data_done), 32'h0);
      check("rst_stall_if", 32'(bus.stall_req_if), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // T1: single load with a 2-cycle data phase
      ao_wait = 0; do_wait = 2; resp_rdata = 32'hDEADBEEF;
      s_dd = n_ddone; s_sm = n_stall_mem;
      push_data(1'b0, 2'd2, 32'h100, 32'h0);
      wait_idle("t1_timeout");
      check("t1_done_pulses", 32'(n_ddone - s_dd), 32'd1);
      check("t1_rdata", last_drdata, 32'hDEADBEEF);
      check("t1_stall_cycles", 32'(n_stall_mem - s_sm), 32'd3);

      // T2: simultaneous requests, zero-wait port
      ao_wait = 0; do_wait = 0; resp_rdata = 32'h0000_1111;
      g0 = glog.size(); s_si = n_stall_if;
      iq.push_back(32'h0);
      push_data(1'b0, 2'd2, 32'h80, 32'h0);
      wait_idle("t2_timeout");
      check("t2_grants", 32'(glog.size() - g0), 32'd2);
      check("t2_first", glog_at(g0), 32'h80);
      check("t2_second", glog_at(g0 + 1), 32'h0);
      check("t2_stall_if_cycles", 32'(n_stall_if - s_si), 32'd3);

      // T3: starvation bound with both requests held
      g0 = glog.size();
      for (int k = 0; k < 5; k++) iq.push_back(32'h1000 + 32'(4 * k));
      for (int k = 0; k < 6; k++) push_data(1'b0, 2'd2, 32'h2000 + 32'(4 * k), 32'h0);
      exp_order = '{32'h2000, 32'h2004, 32'h2008, 32'h1000, 32'h200C, 32'h2010,
                    32'h2014, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
      wait_idle("t3_timeout");
      check("t3_grants", 32'(glog.size() - g0), 32'd11);
      for (int k = 0; k < 11; k++) check($sformatf("t3_order%0d", k), glog_at(g0 + k),
                                         exp_order[k]);

      // T4: address and data accepted in the same cycle
      ao_wait = 0; do_wait = 0; resp_rdata = 32'h12345678;
      s_mr = n_memreq; s_dd = n_ddone;
      push_data(1'b0, 2'd2, 32'h180, 32'h0);
      wait_idle("t4_timeout");
      check("t4_req_cycles", 32'(n_memreq - s_mr), 32'd1);
      check("t4_done_pulses", 32'(n_ddone - s_dd), 32'd1);
      check("t4_rdata", last_drdata, 32'h12345678);
      // Stray data-ok while idle completes nothing
      s_dd = n_ddone; s_id = n_idone;
      @(posedge clk); #2; spur_ok = 1'b1;
      repeat (2) @(posedge clk);
      #2; spur_ok = 1'b0;
      check("t4_stray_ddone", 32'(n_ddone - s_dd), 32'd0);
      check("t4_stray_idone", 32'(n_idone - s_id), 32'd0);

      // T5: byte store with address accept held off 4 cycles
      ao_wait = 4; do_wait = 1;
      s_mr = n_memreq; s_st = n_store_ok; s_dd = n_ddone;
      push_data(1'b1, 2'd0, 32'h300, 32'hAB);
      wait_idle("t5_timeout");
      check("t5_req_cycles", 32'(n_memreq - s_mr), 32'd5);
      check("t5_stable_cycles", 32'(n_store_ok - s_st), 32'd5);
      check("t5_done_pulses", 32'(n_ddone - s_dd), 32'd1);

      // T6: asynchronous reset during the data phase
      ao_wait = 0; do_wait = 20; resp_rdata = 32'h0;
      push_data(1'b1, 2'd2, 32'h400, 32'h77);
      iq.push_back(32'h500);
      repeat (4) @(posedge clk);
      #3;
      check("t6_pre_addr", bus.mem_addr, 32'h400);
      check("t6_pre_stall_if", 32'(bus.stall_req_if), 32'h1);
      rst_n   = 1'b0;
      spur_ok = 1'b1;
      #1;
      check("t6_mem_req", 32'(bus.mem_req), 32'h0);
      check("t6_mem_addr", bus.mem_addr, 32'h0);
      check("t6_mem_wr", 32'(bus.mem_wr), 32'h0);
      check("t6_mem_wdata", bus.mem_wdata, 32'h0);
      check("t6_data_done", 32'(bus.data_done), 32'h0);
      check("t6_inst_done", 32'(bus.inst_done), 32'h0);
      check("t6_stall_if", 32'(bus.stall_req_if), 32'h0);
      check("t6_stall_mem", 32'(bus.stall_req_mem), 32'h0);
      spur_ok = 1'b0;
      kill    = 1'b1;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #3;
      kill = 1'b0;
      ao_wait = 0; do_wait = 1; resp_rdata = 32'hCAFE0001;
      g0 = glog.size(); s_id = n_idone;
      iq.push_back(32'h600);
      wait_idle("t6_timeout");
      check("t6_post_grants", 32'(glog.size() - g0), 32'd1);
      check("t6_post_addr", glog_at(g0), 32'h600);
      check("t6_post_done", 32'(n_idone - s_id), 32'd1);
      check("t6_post_rdata", last_irdata, 32'hCAFE0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
